fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream.sv | 113 +++++++++++
 1 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side adapter that pops words from a sync FIFO
// (empty/rd_en/rd_data) and presents them as a valid/ready stream through a
// 2-entry prefetch buffer, marking every PKT_LEN-th beat with m_last.
// Supports combinational (RD_LATENCY=0) and registered (RD_LATENCY=1) FIFO reads.
// Optional macro FIFO_RD_STREAM_STALL_CNT_EN adds a saturating stall_cnt output.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 0,
   parameter int PKT_LEN    = 4,
   parameter int CNT_WIDTH  = $clog2(PKT_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last
`ifdef FIFO_RD_STREAM_STALL_CNT_EN
   ,
   output logic [15:0]           stall_cnt
`endif
);

   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] mem_q [2];
   logic [DATA_WIDTH-1:0] mem_d [2];
   logic                  headPtr_q, headPtr_d;
   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q, inflight_d;
   logic [CNT_WIDTH-1:0]  bcnt_q, bcnt_d;

   logic                  wrEn;
   logic                  handshake;
   logic                  tailPtr;
   logic                  hasRoom;

   // Pop whenever the FIFO has data and the buffer plus any outstanding read leaves a free slot;
   // m_ready is deliberately kept out of this so there is no ready-to-rd_en combinational path.
   always_comb begin
      hasRoom    = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
      fifo_rd_en = !rst && !flush && !fifo_empty && hasRoom;
      wrEn       = (RD_LATENCY == 0) ? fifo_rd_en : inflight_q;
      tailPtr    = headPtr_q ^ occ_q[0];
   end

   // Stream outputs come straight from the buffer head and are forced quiet while reset is held.
   always_comb begin
      m_valid   = !rst && (occ_q != 2'd0);
      m_data    = rst ? '0 : mem_q[headPtr_q];
      m_last    = m_valid && (bcnt_q == LAST_BEAT);
      handshake = m_valid && m_ready;
   end

   // Next state: retire the head on a handshake, append returning read data at the tail, flush clears.
   always_comb begin
      mem_d      = mem_q;
      headPtr_d  = headPtr_q;
      bcnt_d     = bcnt_q;
      inflight_d = (RD_LATENCY == 1) ? fifo_rd_en : 1'b0;
      occ_d      = occ_q + {1'b0, wrEn} - {1'b0, handshake};
      if (handshake) begin
         headPtr_d = ~headPtr_q;
         bcnt_d    = (bcnt_q == LAST_BEAT) ? '0 : bcnt_q + CNT_WIDTH'(1);
      end
      if (wrEn) begin
         mem_d[tailPtr] = fifo_rd_data;
      end
      if (flush) begin
         occ_d      = 2'd0;
         inflight_d = 1'b0;
         bcnt_d     = '0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
         headPtr_q  <= 1'b0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         bcnt_q     <= '0;
      end else begin
         mem_q      <= mem_d;
         headPtr_q  <= headPtr_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         bcnt_q     <= bcnt_d;
      end
   end

`ifdef FIFO_RD_STREAM_STALL_CNT_EN
   logic [15:0] stallCnt_q;

   // Count cycles where a word waits on downstream, saturating rather than wrapping.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         stallCnt_q <= 16'd0;
      end else if (m_valid && !m_ready && (stallCnt_q != 16'hFFFF)) begin
         stallCnt_q <= stallCnt_q + 16'd1;
      end
   end

   assign stall_cnt = stallCnt_q;
`endif

endmodule
